// File: rtl/mips_defs.sv
// mips_defs: shared opcode, divider-state and constant definitions for the MIPS pipeline
package mips_defs;
  typedef enum logic [4:0] {
    OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  } aluop_t;
  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} div_state_t;
  localparam logic [31:0] ZERO_WORD = 32'h0;
endpackage

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider with sign correction
module div_unit
  import mips_defs::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  div_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] quo, rem, dvs;
  logic        s1, s2;
  logic [32:0] trial;
  assign trial     = {rem, quo[31]} - {1'b0, dvs};
  assign busy      = !cancel && (state == DIV_RUN || (state == IDLE && start));
  assign done      = state == DIV_DONE;
  assign quotient  = (s1 ^ s2) ? -quo : quo;
  assign remainder = s1 ? -rem : rem;
  // FSM plus one shift-subtract step per run cycle; quo shifts the dividend out as quotient bits enter
  always_ff @(posedge clk) begin
    if (rst || cancel) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          quo   <= (signed_div && op1[31]) ? -op1 : op1;
          dvs   <= (signed_div && op2[31]) ? -op2 : op2;
          rem   <= ZERO_WORD;
          s1    <= signed_div && op1[31];
          s2    <= signed_div && op2[31];
          cnt   <= '0;
          state <= DIV_RUN;
        end
        DIV_RUN: begin
          rem   <= trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
          quo   <= {quo[30:0], !trial[32]};
          cnt   <= cnt + 5'd1;
          state <= (cnt == 5'(DIV_CYCLES - 1)) ? DIV_DONE : DIV_RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with ALU, shifter, multiplier, HI/LO and iterative divider
module ex_stage
  import mips_defs::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  aluop,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [4:0]  wd,
  input  logic        wreg,
  input  logic        flush,
  output logic        stallreq,
  output logic [31:0] wdata_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  logic [31:0] result, quotient, remainder;
  logic [63:0] prod;
  logic        div_done;
  assign prod = (aluop == OP_MULT)
              ? $signed({{32{src1[31]}}, src1}) * $signed({{32{src2[31]}}, src2})
              : {32'b0, src1} * {32'b0, src2};
  div_unit #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk(clk), .rst(rst),
    .start((aluop == OP_DIV || aluop == OP_DIVU) && src2 != ZERO_WORD),
    .signed_div(aluop == OP_DIV),
    .op1(src1), .op2(src2),
    .cancel(flush || rst),
    .busy(stallreq), .done(div_done),
    .quotient(quotient), .remainder(remainder)
  );
  // single-cycle result mux; ops that only touch HI/LO produce zero
  always_comb begin
    result = ZERO_WORD;
    case (aluop)
      OP_AND:  result = src1 & src2;
      OP_OR:   result = src1 | src2;
      OP_XOR:  result = src1 ^ src2;
      OP_NOR:  result = ~(src1 | src2);
      OP_ADDU: result = src1 + src2;
      OP_SUBU: result = src1 - src2;
      OP_SLT:  result = {31'b0, $signed(src1) < $signed(src2)};
      OP_SLTU: result = {31'b0, src1 < src2};
      OP_SLL:  result = src2 << src1[4:0];
      OP_SRL:  result = src2 >> src1[4:0];
      OP_SRA:  result = $signed(src2) >>> src1[4:0];
      OP_MFHI: result = hi_o;
      OP_MFLO: result = lo_o;
      default: result = ZERO_WORD;
    endcase
  end
  // EX/MEM register; a stall emits a bubble
  always_ff @(posedge clk) begin
    if (rst || flush || stallreq) begin
      wdata_o <= ZERO_WORD;
      wd_o    <= '0;
      wreg_o  <= 1'b0;
    end else begin
      wdata_o <= result;
      wd_o    <= wd;
      wreg_o  <= wreg;
    end
  end
  // HI/LO update; a finishing divide owns the write in its completion cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= ZERO_WORD;
      lo_o <= ZERO_WORD;
    end else if (!flush && !stallreq) begin
      if (div_done) {hi_o, lo_o} <= {remainder, quotient};
      else if (aluop == OP_MTHI) hi_o <= src1;
      else if (aluop == OP_MTLO) lo_o <= src1;
      else if (aluop == OP_MULT || aluop == OP_MULTU) {hi_o, lo_o} <= prod;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for the execute stage
module tb_ex_stage;
  import mips_defs::*;
  logic        clk = 0, rst = 1, wreg = 0, flush = 0;
  logic [4:0]  aluop = 0, wd = 0;
  logic [31:0] src1 = 0, src2 = 0;
  logic        stallreq, wreg_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic [4:0]  wd_o;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] d; logic [4:0] wd; logic w;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  ex_stage dut (
    .clk(clk), .rst(rst), .aluop(aluop), .src1(src1), .src2(src2), .wd(wd), .wreg(wreg),
    .flush(flush), .stallreq(stallreq), .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic compare(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    x = sb.pop_front();
    check({tag, "_wdata"}, wdata_o, x.d);
    check({tag, "_wd"}, {27'b0, wd_o}, {27'b0, x.wd});
    check({tag, "_wreg"}, {31'b0, wreg_o}, {31'b0, x.w});
  endtask
  task automatic drive(input aluop_t op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    @(negedge clk);
    aluop = op; src1 = a; src2 = b; wd = d; wreg = 1;
  endtask
  task automatic step(input string tag, input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] d, input logic [31:0] e);
    drive(op, a, b, d);
    sb.push_back('{e, d, 1'b1});
    @(posedge clk); #1;
    compare(tag);
  endtask
  task automatic div_op(input string tag, input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [31:0] elo, input logic [31:0] ehi);
    int n = 0;
    drive(op, a, b, d);
    #1;
    while (stallreq && n < 40) begin
      n++;
      if (n > 1) check({tag, "_bubble"}, {31'b0, wreg_o}, 32'd0);
      @(negedge clk); #1;
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'd33);
    check({tag, "_last_bubble"}, {31'b0, wreg_o}, 32'd0);
    sb.push_back('{32'd0, d, 1'b1});
    @(posedge clk); #1;
    compare(tag);
    check({tag, "_lo"}, lo_o, elo);
    check({tag, "_hi"}, hi_o, ehi);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_wdata", wdata_o, 0);
    check("rst_wreg", {31'b0, wreg_o}, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_stall", {31'b0, stallreq}, 0);
    @(negedge clk); rst = 0;
    step("addu", OP_ADDU, 32'hFFFFFFFF, 32'd2, 5'd1, 32'h1);
    step("slt", OP_SLT, 32'hFFFFFFFF, 32'd1, 5'd2, 32'h1);
    step("sltu", OP_SLTU, 32'hFFFFFFFF, 32'd1, 5'd3, 32'h0);
    step("sra", OP_SRA, 32'd4, 32'h80000000, 5'd4, 32'hF8000000);
    step("srl", OP_SRL, 32'd4, 32'h80000000, 5'd5, 32'h08000000);
    step("sll", OP_SLL, 32'd8, 32'h12345678, 5'd6, 32'h34567800);
    step("subu", OP_SUBU, 32'd3, 32'd5, 5'd7, 32'hFFFFFFFE);
    step("and", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd8, 32'hF000F000);
    step("or", OP_OR, 32'hF0F0F0F0, 32'h0000FF00, 5'd9, 32'hF0F0FFF0);
    step("xor", OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd10, 32'h0FF00FF0);
    step("nor", OP_NOR, 32'hF0F0F0F0, 32'h0000FF00, 5'd11, 32'h0F0F000F);
    step("mult", OP_MULT, 32'hFFFFFFFD, 32'd5, 5'd12, 32'h0);
    check("mult_hi", hi_o, 32'hFFFFFFFF);
    check("mult_lo", lo_o, 32'hFFFFFFF1);
    step("mflo", OP_MFLO, 32'd0, 32'd0, 5'd13, 32'hFFFFFFF1);
    step("multu", OP_MULTU, 32'hFFFFFFFD, 32'd5, 5'd14, 32'h0);
    check("multu_hi", hi_o, 32'h4);
    step("mfhi", OP_MFHI, 32'd0, 32'd0, 5'd15, 32'h4);
    step("mthi", OP_MTHI, 32'hCAFEF00D, 32'd0, 5'd16, 32'h0);
    check("mthi_hi", hi_o, 32'hCAFEF00D);
    div_op("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd17, 32'hFFFFFFFD, 32'hFFFFFFFF);
    div_op("divu", OP_DIVU, 32'd100, 32'd7, 5'd18, 32'd14, 32'd2);
    drive(OP_DIVU, 32'd5, 32'd0, 5'd19);
    #1 check("div0_stall", {31'b0, stallreq}, 0);
    sb.push_back('{32'd0, 5'd19, 1'b1});
    @(posedge clk); #1;
    compare("div0");
    check("div0_lo", lo_o, 32'd14);
    check("div0_hi", hi_o, 32'd2);
    drive(OP_DIV, 32'd1000, 32'd3, 5'd20);
    repeat (11) @(negedge clk);
    flush = 1;
    #1 check("flush_stall", {31'b0, stallreq}, 0);
    @(posedge clk); #1;
    check("flush_wreg", {31'b0, wreg_o}, 0);
    check("flush_lo", lo_o, 32'd14);
    check("flush_hi", hi_o, 32'd2);
    @(negedge clk); flush = 0; aluop = OP_NOP;
    #1 check("flush_idle", {31'b0, stallreq}, 0);
    @(posedge clk); #1;
    check("flush_after_lo", lo_o, 32'd14);
    drive(OP_DIVU, 32'd1000, 32'd3, 5'd21);
    repeat (5) @(negedge clk);
    rst = 1;
    #1 check("rst_mid_stall", {31'b0, stallreq}, 0);
    @(posedge clk); #1;
    check("rst_mid_wdata", wdata_o, 0);
    check("rst_mid_wd", {27'b0, wd_o}, 0);
    check("rst_mid_wreg", {31'b0, wreg_o}, 0);
    check("rst_mid_hi", hi_o, 0);
    check("rst_mid_lo", lo_o, 0);
    @(negedge clk); rst = 0; aluop = OP_NOP;
    #1 check("rst_mid_idle", {31'b0, stallreq}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
